sha256_padder: RTL and testbench
================================

SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter NUM_OF_WORDS, default 20, meaning message length in 32-bit words (range 1..1023).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  begin padding the message at message_addr; sampled only in IDLE.
REQ-005 SHALL have port message_addr  input  16  word address of message word 0; captured when start is accepted.
REQ-006 SHALL have port done  output  1  high exactly while in IDLE.
REQ-007 SHALL have ports mem_clk (output, 1, equals clk), mem_we (output, 1, constant 0), mem_addr (output, 16, read word address) and mem_read_data (input, 32, read data).
REQ-008 SHALL have ports blk_valid (output, 1), blk_ready (input, 1), blk_word (output, 32), blk_idx (output, 4, word index 0..15 within block), blk_last (output, 1, high on word 15 of the final block).

Function
REQ-009 SHALL assume memory read latency of one cycle: address driven in cycle n, data sampled at the end of cycle n+1.
REQ-010 SHALL compute NB = ceil((NUM_OF_WORDS+3)/16) blocks at elaboration.
REQ-011 SHALL define global word g = 16*b + w: g<N gives memory word; g==N gives 32'h80000000; last block w==14 gives 0; last block w==15 gives N*32; all other words 0.
REQ-012 SHALL use states IDLE, FETCH and EMIT.
REQ-013 SHALL go IDLE->FETCH on start, clearing block counter b to 0.
REQ-014 SHALL have FETCH last exactly 17 cycles: mem_addr = message_addr+16*b+c for c=0..15, and buffer word c loads on cycle c+1.
REQ-015 SHALL load the pad/length value from REQ-011 into buffer words with g>=N; their mem_read_data is ignored.
REQ-016 SHALL go FETCH->EMIT after the 17th cycle.
REQ-017 SHALL in EMIT hold blk_valid high and present buffer word blk_idx; a word transfers on a cycle with blk_valid & blk_ready.
REQ-018 SHALL keep blk_word and blk_idx stable while blk_valid & ~blk_ready.
REQ-019 SHALL, after the transfer of word 15, go to FETCH with b+1 if b<NB-1, else to IDLE.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 SHALL hold blk_valid at 0 outside EMIT.
REQ-022 SHALL use 32-bit unsigned arithmetic for the length word, and 16-bit modular (wrapping) arithmetic for addresses.

Reset
REQ-023 SHALL, when reset_n is low at a clock edge, enter IDLE with blk_valid=0, blk_idx=0, blk_last=0, blk_word=0, mem_addr=0, b=0, aborting any block in progress.
REQ-024 SHALL keep mem_we=0 at all times.

Configuration
REQ-025 SHALL, with macro SHA256_PAD_BSWAP_EN defined, byte-reverse each memory word before buffering (little-endian memory); pad and length words are not swapped.
REQ-026 SHALL, without SHA256_PAD_BSWAP_EN, buffer memory words unchanged.

Structure
REQ-027 SHALL take the state enum, the 32'h80000000 pad constant and a num_blocks function from shared package sha256_pkg, which also holds the K table and IV constants.
REQ-028 SHALL need no sub-module; the 16x32 buffer and the pad-word select stay inline.

Verification
REQ-029 SHALL cover: N=20, mem[a+i]=i+1 -> 2 blocks; block0 words 1..16; block1 words 17..20, 0x80000000, zeros, word15=0x00000280, blk_last on that word only.
REQ-030 SHALL cover: N=13 -> 1 block; word13=0x80000000, word14=0, word15=0x000001A0; done after last transfer.
REQ-031 SHALL cover: N=14 -> 2 blocks; block0 word14=0x80000000, word15=0; block1 all zero except word15=0x000001C0.
REQ-032 SHALL cover: blk_ready low 5 cycles mid-block -> blk_word/blk_idx stable, no word lost or duplicated.
REQ-033 SHALL cover: reset_n low during EMIT word 7 -> next cycle IDLE, done=1, blk_valid=0; a fresh start yields a correct block 0.
REQ-034 SHALL cover: with SHA256_PAD_BSWAP_EN, memory word 0x11223344 -> blk_word 0x44332211, and the length word is unchanged.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM states, pad constant, block-count helper,
// round constants and initial hash value.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2
  } pad_state_e;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Blocks needed for the message plus pad word plus 64-bit length (two words).
  function automatic int unsigned num_blocks(input int unsigned num_words);
    return (num_words + 3 + 15) / 16;
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: reads NUM_OF_WORDS words from a one-cycle-latency memory,
// appends the 0x80000000 pad word, zero fill and bit length, and streams 16-word blocks.
// Define SHA256_PAD_BSWAP_EN to byte-reverse memory words (little-endian memory).
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [31:0] blk_word,
  output logic [3:0]  blk_idx,
  output logic        blk_last
);

  localparam int unsigned NB       = num_blocks(NUM_OF_WORDS);
  localparam int unsigned BLK_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NB - 1);
  localparam logic [31:0] LEN_WORD = 32'(NUM_OF_WORDS * 32);

  pad_state_e       state_q;
  logic [BLK_W-1:0] blk_q;
  logic [4:0]       cnt_q;
  logic [15:0]      base_q;
  logic [31:0]      buf_q [16];

  logic [3:0]  fill_w;
  logic [31:0] fill_g;
  logic [31:0] mem_word;
  logic [31:0] fill_word;
  logic        is_last_blk;

  assign mem_clk   = clk;
  assign mem_we    = 1'b0;
  assign done      = (state_q == IDLE);
  assign blk_valid = (state_q == EMIT);

  // Select the word written into the buffer this FETCH cycle: memory data or pad/length.
  always_comb begin
    fill_w      = 4'(cnt_q - 5'd1);
    fill_g      = (32'(blk_q) << 4) + 32'(fill_w);
    is_last_blk = (blk_q == LAST_BLK);
`ifdef SHA256_PAD_BSWAP_EN
    mem_word = {mem_read_data[7:0], mem_read_data[15:8],
                mem_read_data[23:16], mem_read_data[31:24]};
`else
    mem_word = mem_read_data;
`endif
    if (fill_g < NUM_OF_WORDS) begin
      fill_word = mem_word;
    end else if (fill_g == NUM_OF_WORDS) begin
      fill_word = PAD_WORD;
    end else if (is_last_blk && (fill_w == 4'd15)) begin
      fill_word = LEN_WORD;
    end else begin
      fill_word = 32'd0;
    end
  end

  // Block buffer: word c captures the read issued one cycle earlier (FETCH cycle c+1).
  always_ff @(posedge clk) begin
    if (reset_n && (state_q == FETCH) && (cnt_q != 5'd0)) begin
      buf_q[fill_w] <= fill_word;
    end
  end

  // Control FSM with registered address and block-stream outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      blk_q    <= '0;
      cnt_q    <= 5'd0;
      base_q   <= 16'd0;
      mem_addr <= 16'd0;
      blk_idx  <= 4'd0;
      blk_word <= 32'd0;
      blk_last <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= FETCH;
            blk_q    <= '0;
            cnt_q    <= 5'd0;
            base_q   <= message_addr;
            mem_addr <= message_addr;
          end
        end
        FETCH: begin
          mem_addr <= mem_addr + 16'd1;
          if (cnt_q == 5'd16) begin
            state_q  <= EMIT;
            blk_idx  <= 4'd0;
            blk_word <= buf_q[0];
            blk_last <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        EMIT: begin
          if (blk_ready) begin
            if (blk_idx == 4'd15) begin
              blk_idx  <= 4'd0;
              blk_last <= 1'b0;
              if (is_last_blk) begin
                state_q <= IDLE;
              end else begin
                state_q  <= FETCH;
                blk_q    <= blk_q + 1'b1;
                cnt_q    <= 5'd0;
                mem_addr <= base_q + ((16'(blk_q) + 16'd1) << 4);
              end
            end else begin
              blk_idx  <= blk_idx + 4'd1;
              blk_word <= buf_q[blk_idx + 4'd1];
              blk_last <= is_last_blk && (blk_idx == 4'd14);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: three instances (N=20, 13, 14) share one memory
// model; the expected block stream is built directly from the padding rules.
module tb_sha256_padder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        blk_ready;
  logic [15:0] message_addr;
  logic [2:0]  start_v;
  logic [2:0]  done_v, valid_v, last_v, we_v, mclk_v;
  logic [31:0] word_v [3];
  logic [3:0]  idx_v [3];
  logic [15:0] addr_v [3];
  logic [31:0] rd_v [3];
  logic [31:0] mem [65536];

  logic [1:0]  sel;
  logic        sv_done, sv_valid, sv_last;
  logic [31:0] sv_word;
  logic [3:0]  sv_idx;

  int checks = 0;
  int failures = 0;

  logic [31:0] rx_w[$];
  logic [3:0]  rx_i[$];
  logic        rx_l[$];
  logic [31:0] exp_w[$];
  logic [3:0]  exp_i[$];
  logic        exp_l[$];
  logic        timed_out;
  int          stall_bad;

  sha256_padder #(.NUM_OF_WORDS(20)) u_n20 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .message_addr(message_addr),
    .done(done_v[0]), .mem_clk(mclk_v[0]), .mem_we(we_v[0]), .mem_addr(addr_v[0]),
    .mem_read_data(rd_v[0]), .blk_valid(valid_v[0]), .blk_ready(blk_ready),
    .blk_word(word_v[0]), .blk_idx(idx_v[0]), .blk_last(last_v[0])
  );
  sha256_padder #(.NUM_OF_WORDS(13)) u_n13 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .message_addr(message_addr),
    .done(done_v[1]), .mem_clk(mclk_v[1]), .mem_we(we_v[1]), .mem_addr(addr_v[1]),
    .mem_read_data(rd_v[1]), .blk_valid(valid_v[1]), .blk_ready(blk_ready),
    .blk_word(word_v[1]), .blk_idx(idx_v[1]), .blk_last(last_v[1])
  );
  sha256_padder #(.NUM_OF_WORDS(14)) u_n14 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .message_addr(message_addr),
    .done(done_v[2]), .mem_clk(mclk_v[2]), .mem_we(we_v[2]), .mem_addr(addr_v[2]),
    .mem_read_data(rd_v[2]), .blk_valid(valid_v[2]), .blk_ready(blk_ready),
    .blk_word(word_v[2]), .blk_idx(idx_v[2]), .blk_last(last_v[2])
  );

  initial forever #5 clk = ~clk;

  // Synchronous memory, one cycle of read latency per instance.
  always @(posedge clk) begin
    rd_v[0] <= mem[addr_v[0]];
    rd_v[1] <= mem[addr_v[1]];
    rd_v[2] <= mem[addr_v[2]];
  end

  always_comb begin
    sv_done  = done_v[sel];
    sv_valid = valid_v[sel];
    sv_last  = last_v[sel];
    sv_word  = word_v[sel];
    sv_idx   = idx_v[sel];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned nw(input logic [1:0] s);
    case (s)
      2'd0:    return 20;
      2'd1:    return 13;
      default: return 14;
    endcase
  endfunction

  function automatic logic [31:0] mem_view(input logic [31:0] x);
    logic [31:0] r;
`ifdef SHA256_PAD_BSWAP_EN
    r = {<<8{x}};
`else
    r = x;
`endif
    return r;
  endfunction

  // Reference stream: message, one pad word, zeros, bit length in the final slot.
  function automatic void build_exp(input int unsigned n, input logic [15:0] base);
    int unsigned total;
    logic [31:0] v;
    logic [15:0] a;
    total = ((n + 3 + 15) / 16) * 16;
    exp_w.delete(); exp_i.delete(); exp_l.delete();
    for (int unsigned g = 0; g < total; g++) begin
      a = base + 16'(g);
      if (g < n) v = mem_view(mem[a]);
      else if (g == n) v = 32'h8000_0000;
      else if (g == total - 1) v = n * 32;
      else v = 32'd0;
      exp_w.push_back(v);
      exp_i.push_back(4'(g % 16));
      exp_l.push_back(g == total - 1);
    end
  endfunction

  task automatic kick(input logic [1:0] s, input logic [15:0] base);
    @(negedge clk);
    sel = s;
    message_addr = base;
    start_v = 3'b000;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v = 3'b000;
  endtask

  // Gather nwords transfers with random backpressure, an optional forced stall, and an
  // optional spurious start pulse while busy.
  task automatic collect(input int nwords, input int stall_at, input int stall_len,
                         input bit poke);
    int got = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled = 0;
    logic [31:0] hw;
    logic [3:0] hi;
    rx_w.delete(); rx_i.delete(); rx_l.delete();
    timed_out = 0;
    stall_bad = 0;
    while (got < nwords) begin
      @(negedge clk);
      cyc++;
      if (cyc > 2000) begin
        timed_out = 1;
        break;
      end
      start_v[sel] = poke && (got == 3);
      if (!stalled && got == stall_at && sv_valid) begin
        stalled = 1;
        stall_left = stall_len;
        hw = sv_word;
        hi = sv_idx;
      end
      if (stall_left > 0) begin
        blk_ready = 1'b0;
        if (!sv_valid || sv_word !== hw || sv_idx !== hi) stall_bad++;
        stall_left--;
      end else begin
        blk_ready = ($urandom_range(0, 3) != 0);
      end
      if (blk_ready && sv_valid) begin
        rx_w.push_back(sv_word);
        rx_i.push_back(sv_idx);
        rx_l.push_back(sv_last);
        got++;
      end
    end
    start_v = 3'b000;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    blk_ready = 1'b0;
    start_v = 3'b000;
    message_addr = 16'h0;
    sel = 2'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (done_v[s] !== 1'b1 || valid_v[s] !== 1'b0 || idx_v[s] !== 4'd0 ||
          last_v[s] !== 1'b0 || word_v[s] !== 32'd0 || addr_v[s] !== 16'd0 ||
          we_v[s] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state[%0d] got done=%b valid=%b idx=%0d last=%b word=%h addr=%h we=%b exp 1 0 0 0 0 0 0",
                 s, done_v[s], valid_v[s], idx_v[s], last_v[s], word_v[s], addr_v[s], we_v[s]);
      end
    end
  endtask

  task automatic test_n20;
    logic [15:0] base = 16'($urandom);
    for (int i = 0; i < 20; i++) mem[16'(base + 16'(i))] = 32'(i + 1);
    build_exp(nw(0), base);
    kick(2'd0, base);
    collect(32, -1, 0, 0);
    checks++;
    if (timed_out || rx_w.size() != exp_w.size()) begin
      failures++;
      $display("FAIL n20_count got %0d words exp %0d", rx_w.size(), exp_w.size());
    end
    for (int i = 0; i < rx_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (rx_w[i] !== exp_w[i] || rx_i[i] !== exp_i[i] || rx_l[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL n20_word[%0d] got w=%h i=%0d l=%b exp w=%h i=%0d l=%b",
                 i, rx_w[i], rx_i[i], rx_l[i], exp_w[i], exp_i[i], exp_l[i]);
      end
    end
    checks++;
    if (rx_w.size() == 32 && (rx_w[31] !== 32'h0000_0280 || rx_w[20] !== 32'h8000_0000)) begin
      failures++;
      $display("FAIL n20_len_word got w15=%h w4=%h exp 00000280 80000000", rx_w[31], rx_w[20]);
    end
    @(negedge clk);
    checks++;
    if (sv_done !== 1'b1 || sv_valid !== 1'b0) begin
      failures++;
      $display("FAIL n20_done got done=%b valid=%b exp 1 0", sv_done, sv_valid);
    end
  endtask

  task automatic test_n13;
    logic [15:0] base = 16'($urandom);
    for (int i = 0; i < 16; i++) mem[16'(base + 16'(i))] = $urandom;
    build_exp(nw(1), base);
    kick(2'd1, base);
    collect(16, -1, 0, 0);
    checks++;
    if (timed_out || rx_w.size() != 16) begin
      failures++;
      $display("FAIL n13_count got %0d words exp 16", rx_w.size());
    end
    for (int i = 0; i < rx_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (rx_w[i] !== exp_w[i] || rx_i[i] !== exp_i[i] || rx_l[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL n13_word[%0d] got w=%h i=%0d l=%b exp w=%h i=%0d l=%b",
                 i, rx_w[i], rx_i[i], rx_l[i], exp_w[i], exp_i[i], exp_l[i]);
      end
    end
    checks++;
    if (rx_w.size() == 16 && (rx_w[13] !== 32'h8000_0000 || rx_w[14] !== 32'd0 ||
                              rx_w[15] !== 32'h0000_01A0)) begin
      failures++;
      $display("FAIL n13_tail got %h %h %h exp 80000000 00000000 000001a0",
               rx_w[13], rx_w[14], rx_w[15]);
    end
    @(negedge clk);
    checks++;
    if (sv_done !== 1'b1 || sv_valid !== 1'b0) begin
      failures++;
      $display("FAIL n13_done got done=%b valid=%b exp 1 0", sv_done, sv_valid);
    end
  endtask

  task automatic test_n14;
    logic [15:0] base = 16'($urandom);
    for (int i = 0; i < 32; i++) mem[16'(base + 16'(i))] = $urandom;
    build_exp(nw(2), base);
    kick(2'd2, base);
    collect(32, -1, 0, 0);
    checks++;
    if (timed_out || rx_w.size() != 32) begin
      failures++;
      $display("FAIL n14_count got %0d words exp 32", rx_w.size());
    end
    for (int i = 0; i < rx_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (rx_w[i] !== exp_w[i] || rx_i[i] !== exp_i[i] || rx_l[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL n14_word[%0d] got w=%h i=%0d l=%b exp w=%h i=%0d l=%b",
                 i, rx_w[i], rx_i[i], rx_l[i], exp_w[i], exp_i[i], exp_l[i]);
      end
    end
    checks++;
    if (rx_w.size() == 32 && (rx_w[14] !== 32'h8000_0000 || rx_w[15] !== 32'd0 ||
                              rx_w[16] !== 32'd0 || rx_w[31] !== 32'h0000_01C0)) begin
      failures++;
      $display("FAIL n14_pad got b0w14=%h b0w15=%h b1w0=%h b1w15=%h exp 80000000 0 0 000001c0",
               rx_w[14], rx_w[15], rx_w[16], rx_w[31]);
    end
  endtask

  task automatic test_stall_and_ignore_start;
    logic [15:0] base = 16'hFFF5;  // crosses the 16-bit address wrap
    for (int i = 0; i < 20; i++) mem[16'(base + 16'(i))] = $urandom;
    build_exp(nw(0), base);
    kick(2'd0, base);
    collect(32, 21, 5, 1);
    checks++;
    if (timed_out || rx_w.size() != 32 || stall_bad != 0) begin
      failures++;
      $display("FAIL stall_count got %0d words unstable=%0d exp 32 words unstable=0",
               rx_w.size(), stall_bad);
    end
    for (int i = 0; i < rx_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (rx_w[i] !== exp_w[i] || rx_i[i] !== exp_i[i] || rx_l[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL stall_word[%0d] got w=%h i=%0d l=%b exp w=%h i=%0d l=%b",
                 i, rx_w[i], rx_i[i], rx_l[i], exp_w[i], exp_i[i], exp_l[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (sv_done !== 1'b1 || sv_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_done got done=%b valid=%b exp 1 0", sv_done, sv_valid);
    end
  endtask

  task automatic test_reset_mid_emit;
    logic [15:0] base = 16'($urandom);
    bit hit = 0;
    for (int i = 0; i < 20; i++) mem[16'(base + 16'(i))] = $urandom;
    kick(2'd0, base);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      blk_ready = 1'b1;
      if (sv_valid && sv_idx == 4'd7) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rst_mid_reach got no word 7 exp word 7 presented");
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (sv_done !== 1'b1 || sv_valid !== 1'b0 || sv_idx !== 4'd0 || sv_last !== 1'b0 ||
        sv_word !== 32'd0 || addr_v[0] !== 16'd0) begin
      failures++;
      $display("FAIL rst_mid_state got done=%b valid=%b idx=%0d last=%b word=%h addr=%h exp 1 0 0 0 0 0",
               sv_done, sv_valid, sv_idx, sv_last, sv_word, addr_v[0]);
    end
    build_exp(nw(0), base);
    kick(2'd0, base);
    collect(32, -1, 0, 0);
    checks++;
    if (timed_out || rx_w.size() != 32) begin
      failures++;
      $display("FAIL rst_mid_count got %0d words exp 32", rx_w.size());
    end
    for (int i = 0; i < rx_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (rx_w[i] !== exp_w[i] || rx_i[i] !== exp_i[i] || rx_l[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL rst_mid_word[%0d] got w=%h i=%0d l=%b exp w=%h i=%0d l=%b",
                 i, rx_w[i], rx_i[i], rx_l[i], exp_w[i], exp_i[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_bswap;
    logic [15:0] base = 16'($urandom);
    logic [31:0] want0;
`ifdef SHA256_PAD_BSWAP_EN
    want0 = 32'h4433_2211;
`else
    want0 = 32'h1122_3344;
`endif
    mem[base] = 32'h1122_3344;
    for (int i = 1; i < 13; i++) mem[16'(base + 16'(i))] = $urandom;
    kick(2'd1, base);
    collect(16, -1, 0, 0);
    checks++;
    if (rx_w.size() != 16 || rx_w[0] !== want0 || rx_w[15] !== 32'h0000_01A0 ||
        rx_w[13] !== 32'h8000_0000) begin
      failures++;
      $display("FAIL bswap got n=%0d w0=%h w13=%h w15=%h exp n=16 w0=%h w13=80000000 w15=000001a0",
               rx_w.size(), rx_w[0], rx_w[13], rx_w[15], want0);
    end
    checks++;
    if (we_v !== 3'b000 || mclk_v !== {3{clk}}) begin
      failures++;
      $display("FAIL mem_ctrl got we=%b mclk=%b exp we=000 mclk=%b", we_v, mclk_v, {3{clk}});
    end
  endtask

  initial begin
    test_reset();
    test_n20();
    test_n13();
    test_n14();
    test_stall_and_ignore_start();
    test_reset_mid_emit();
    test_bswap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
